// File: rtl/tinyrv1_pkg.sv
// Shared TinyRV1 pipeline definitions: register/word sizes, bypass source select
// and the source-match helper used by the operand-fetch bypass network.
package tinyrv1_pkg;

    localparam int         XLEN     = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [2:0] {
        BYP_ZERO,
        BYP_X,
        BYP_M,
        BYP_W,
        BYP_RF
    } byp_sel_t;

    // A later stage supplies a source only if it really writes that non-zero register
    // and the instruction in decode really reads it.
    function automatic logic srcMatch(input logic       stageVal,
                                      input logic       stageWen,
                                      input logic [4:0] stageRd,
                                      input logic [4:0] src,
                                      input logic       srcUsed);
        return stageVal & stageWen & (stageRd == src) & (src != REG_ZERO) & srcUsed;
    endfunction

endpackage

// File: rtl/operand_bypass.sv
// Resolves one source operand from the regfile or the X/M/W bypass paths and flags
// when that source cannot be supplied this cycle. Forwarding exists only with OPFETCH_BYPASS_EN.
module operand_bypass
    import tinyrv1_pkg::*;
(
    input  logic [4:0]      src_i,
    input  logic            src_use_i,
    input  logic            x_val_i,
    input  logic            x_wen_i,
    input  logic            x_is_load_i,
    input  logic [4:0]      x_rd_i,
    input  logic [XLEN-1:0] x_wdata_i,
    input  logic            m_val_i,
    input  logic            m_wen_i,
    input  logic [4:0]      m_rd_i,
    input  logic [XLEN-1:0] m_wdata_i,
    input  logic            w_val_i,
    input  logic            w_wen_i,
    input  logic [4:0]      w_rd_i,
    input  logic [XLEN-1:0] w_wdata_i,
    input  logic [XLEN-1:0] rf_rdata_i,
    output logic [XLEN-1:0] operand_o,
    output logic            hazard_o
);

    logic     xMatch;
    logic     mMatch;
    logic     wMatch;
    byp_sel_t sel;

    assign xMatch = srcMatch(x_val_i, x_wen_i, x_rd_i, src_i, src_use_i);
    assign mMatch = srcMatch(m_val_i, m_wen_i, m_rd_i, src_i, src_use_i);
    assign wMatch = srcMatch(w_val_i, w_wen_i, w_rd_i, src_i, src_use_i);

`ifdef OPFETCH_BYPASS_EN
    // Youngest writer wins; a load in X has no data yet, so it must stall instead.
    always_comb begin
        sel = BYP_RF;
        if (src_i == REG_ZERO) sel = BYP_ZERO;
        else if (xMatch)       sel = BYP_X;
        else if (mMatch)       sel = BYP_M;
        else if (wMatch)       sel = BYP_W;
    end

    assign hazard_o = xMatch & x_is_load_i;
`else
    // The regfile write lands on the edge after the read, so even a W match must wait.
    always_comb begin
        sel = BYP_RF;
        if (src_i == REG_ZERO) sel = BYP_ZERO;
    end

    assign hazard_o = xMatch | mMatch | wMatch;

    logic unusedBypass;
    assign unusedBypass = ^{x_wdata_i, m_wdata_i, w_wdata_i, x_is_load_i};
`endif

    always_comb begin
        operand_o = rf_rdata_i;
        case (sel)
            BYP_ZERO: operand_o = '0;
            BYP_X:    operand_o = x_wdata_i;
            BYP_M:    operand_o = m_wdata_i;
            BYP_W:    operand_o = w_wdata_i;
            default:  operand_o = rf_rdata_i;
        endcase
    end

endmodule

// File: rtl/operand_fetch.sv
// TinyRV1 operand-fetch stage: regfile read, per-source bypass, load-use stall, a
// single-entry val/rdy output register and a saturating stall counter (OPFETCH_BYPASS_EN).
module operand_fetch
    import tinyrv1_pkg::*;
#(
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_val,
    output logic              d_rdy,
    input  logic [4:0]        d_rs1,
    input  logic [4:0]        d_rs2,
    input  logic              d_use_rs1,
    input  logic              d_use_rs2,
    input  logic [4:0]        d_rd,
    input  logic              d_wen,
    input  logic [CTRL_W-1:0] d_ctrl,
    output logic [4:0]        rf_raddr0,
    output logic [4:0]        rf_raddr1,
    input  logic [XLEN-1:0]   rf_rdata0,
    input  logic [XLEN-1:0]   rf_rdata1,
    input  logic              x_val,
    input  logic              x_wen,
    input  logic              x_is_load,
    input  logic [4:0]        x_rd,
    input  logic [XLEN-1:0]   x_wdata,
    input  logic              m_val,
    input  logic              m_wen,
    input  logic [4:0]        m_rd,
    input  logic [XLEN-1:0]   m_wdata,
    input  logic              w_val,
    input  logic              w_wen,
    input  logic [4:0]        w_rd,
    input  logic [XLEN-1:0]   w_wdata,
    input  logic              squash,
    output logic              o_val,
    input  logic              o_rdy,
    output logic [XLEN-1:0]   o_op0,
    output logic [XLEN-1:0]   o_op1,
    output logic [4:0]        o_rd,
    output logic              o_wen,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [31:0]       stall_cnt
);

    logic [XLEN-1:0]   operand0;
    logic [XLEN-1:0]   operand1;
    logic              srcHazard0;
    logic              srcHazard1;
    logic              hazard;
    logic              accept;
    logic              stallEvent;

    logic              oVal_q,   oVal_d;
    logic [XLEN-1:0]   op0_q,    op0_d;
    logic [XLEN-1:0]   op1_q,    op1_d;
    logic [4:0]        rd_q,     rd_d;
    logic              wen_q,    wen_d;
    logic [CTRL_W-1:0] ctrl_q,   ctrl_d;
    logic [31:0]       stallCnt_q, stallCnt_d;

    assign rf_raddr0 = d_rs1;
    assign rf_raddr1 = d_rs2;

    operand_bypass u_bypass0 (
        .src_i       (d_rs1),
        .src_use_i   (d_use_rs1),
        .x_val_i     (x_val),
        .x_wen_i     (x_wen),
        .x_is_load_i (x_is_load),
        .x_rd_i      (x_rd),
        .x_wdata_i   (x_wdata),
        .m_val_i     (m_val),
        .m_wen_i     (m_wen),
        .m_rd_i      (m_rd),
        .m_wdata_i   (m_wdata),
        .w_val_i     (w_val),
        .w_wen_i     (w_wen),
        .w_rd_i      (w_rd),
        .w_wdata_i   (w_wdata),
        .rf_rdata_i  (rf_rdata0),
        .operand_o   (operand0),
        .hazard_o    (srcHazard0)
    );

    operand_bypass u_bypass1 (
        .src_i       (d_rs2),
        .src_use_i   (d_use_rs2),
        .x_val_i     (x_val),
        .x_wen_i     (x_wen),
        .x_is_load_i (x_is_load),
        .x_rd_i      (x_rd),
        .x_wdata_i   (x_wdata),
        .m_val_i     (m_val),
        .m_wen_i     (m_wen),
        .m_rd_i      (m_rd),
        .m_wdata_i   (m_wdata),
        .w_val_i     (w_val),
        .w_wen_i     (w_wen),
        .w_rd_i      (w_rd),
        .w_wdata_i   (w_wdata),
        .rf_rdata_i  (rf_rdata1),
        .operand_o   (operand1),
        .hazard_o    (srcHazard1)
    );

    // squash is deliberately kept out of d_rdy; it only gates whether the handshake takes effect.
    assign hazard     = d_val & (srcHazard0 | srcHazard1);
    assign d_rdy      = ~hazard & (~oVal_q | o_rdy);
    assign accept     = d_val & d_rdy & ~squash;
    assign stallEvent = d_val & ~d_rdy & ~squash;

    always_comb begin
        oVal_d     = oVal_q;
        op0_d      = op0_q;
        op1_d      = op1_q;
        rd_d       = rd_q;
        wen_d      = wen_q;
        ctrl_d     = ctrl_q;
        stallCnt_d = stallCnt_q;

        if (squash) begin
            oVal_d = 1'b0;
        end else if (accept) begin
            oVal_d = 1'b1;
            op0_d  = operand0;
            op1_d  = operand1;
            rd_d   = d_rd;
            wen_d  = d_wen & (d_rd != REG_ZERO);
            ctrl_d = d_ctrl;
        end else if (o_rdy) begin
            oVal_d = 1'b0;
        end

        if (stallEvent && (stallCnt_q != 32'hFFFF_FFFF)) begin
            stallCnt_d = stallCnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oVal_q     <= 1'b0;
            op0_q      <= '0;
            op1_q      <= '0;
            rd_q       <= '0;
            wen_q      <= 1'b0;
            ctrl_q     <= '0;
            stallCnt_q <= '0;
        end else begin
            oVal_q     <= oVal_d;
            op0_q      <= op0_d;
            op1_q      <= op1_d;
            rd_q       <= rd_d;
            wen_q      <= wen_d;
            ctrl_q     <= ctrl_d;
            stallCnt_q <= stallCnt_d;
        end
    end

    assign o_val     = oVal_q;
    assign o_op0     = op0_q;
    assign o_op1     = op1_q;
    assign o_rd      = rd_q;
    assign o_wen     = wen_q;
    assign o_ctrl    = ctrl_q;
    assign stall_cnt = stallCnt_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: a reference model of the stage predicts d_rdy,
// stall_cnt and each accepted instruction, which is queued and matched against o_*.
module tb_operand_fetch;

    localparam int CTRL_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              d_val;
    logic              d_rdy;
    logic [4:0]        d_rs1, d_rs2, d_rd;
    logic              d_use_rs1, d_use_rs2, d_wen;
    logic [CTRL_W-1:0] d_ctrl;
    logic [4:0]        rf_raddr0, rf_raddr1;
    logic [31:0]       rf_rdata0, rf_rdata1;
    logic              x_val, x_wen, x_is_load;
    logic [4:0]        x_rd;
    logic [31:0]       x_wdata;
    logic              m_val, m_wen;
    logic [4:0]        m_rd;
    logic [31:0]       m_wdata;
    logic              w_val, w_wen;
    logic [4:0]        w_rd;
    logic [31:0]       w_wdata;
    logic              squash;
    logic              o_val;
    logic              o_rdy;
    logic [31:0]       o_op0, o_op1;
    logic [4:0]        o_rd;
    logic              o_wen;
    logic [CTRL_W-1:0] o_ctrl;
    logic [31:0]       stall_cnt;

    typedef struct {
        logic [31:0]       op0;
        logic [31:0]       op1;
        logic [4:0]        rd;
        logic              wen;
        logic [CTRL_W-1:0] ctrl;
    } expEntry_t;

    expEntry_t   sb[$];
    logic        oValExp;
    logic [31:0] stallExp;
    int          assertCount = 0;
    int          failCount   = 0;

    operand_fetch #(.CTRL_W(CTRL_W)) dut (
        .clk(clk), .rst(rst),
        .d_val(d_val), .d_rdy(d_rdy), .d_rs1(d_rs1), .d_rs2(d_rs2),
        .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2), .d_rd(d_rd), .d_wen(d_wen), .d_ctrl(d_ctrl),
        .rf_raddr0(rf_raddr0), .rf_raddr1(rf_raddr1), .rf_rdata0(rf_rdata0), .rf_rdata1(rf_rdata1),
        .x_val(x_val), .x_wen(x_wen), .x_is_load(x_is_load), .x_rd(x_rd), .x_wdata(x_wdata),
        .m_val(m_val), .m_wen(m_wen), .m_rd(m_rd), .m_wdata(m_wdata),
        .w_val(w_val), .w_wen(w_wen), .w_rd(w_rd), .w_wdata(w_wdata),
        .squash(squash),
        .o_val(o_val), .o_rdy(o_rdy), .o_op0(o_op0), .o_op1(o_op1),
        .o_rd(o_rd), .o_wen(o_wen), .o_ctrl(o_ctrl), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic stageMatch(input logic v, input logic we, input logic [4:0] rd,
                                        input logic [4:0] s, input logic u);
        return v && we && (rd == s) && (s != 5'd0) && u;
    endfunction

    function automatic logic [31:0] expOperand(input logic [4:0] s, input logic u, input logic [31:0] rf);
        if (s == 5'd0) return 32'd0;
`ifdef OPFETCH_BYPASS_EN
        if (stageMatch(x_val, x_wen, x_rd, s, u)) return x_wdata;
        if (stageMatch(m_val, m_wen, m_rd, s, u)) return m_wdata;
        if (stageMatch(w_val, w_wen, w_rd, s, u)) return w_wdata;
`endif
        return rf;
    endfunction

    function automatic logic expHazard(input logic [4:0] s, input logic u);
`ifdef OPFETCH_BYPASS_EN
        return stageMatch(x_val, x_wen, x_rd, s, u) && x_is_load;
`else
        return stageMatch(x_val, x_wen, x_rd, s, u) || stageMatch(m_val, m_wen, m_rd, s, u) ||
               stageMatch(w_val, w_wen, w_rd, s, u);
`endif
    endfunction

    // Called just after a falling edge with inputs already driven; returns at the next falling edge.
    task automatic applyStimulus();
        logic      hz;
        logic      rdyExp;
        logic      acc;
        expEntry_t e;
        #1;
        checkOutput("rf_raddr0", 32'(rf_raddr0), 32'(d_rs1));
        checkOutput("rf_raddr1", 32'(rf_raddr1), 32'(d_rs2));
        hz     = d_val && (expHazard(d_rs1, d_use_rs1) || expHazard(d_rs2, d_use_rs2));
        rdyExp = !hz && (!oValExp || o_rdy);
        checkOutput("d_rdy", 32'(d_rdy), 32'(rdyExp));
        checkOutput("o_val", 32'(o_val), 32'(oValExp));
        if (oValExp && sb.size() > 0) begin
            checkOutput("o_op0",  o_op0,        sb[0].op0);
            checkOutput("o_op1",  o_op1,        sb[0].op1);
            checkOutput("o_rd",   32'(o_rd),    32'(sb[0].rd));
            checkOutput("o_wen",  32'(o_wen),   32'(sb[0].wen));
            checkOutput("o_ctrl", 32'(o_ctrl),  32'(sb[0].ctrl));
        end
        acc = d_val && rdyExp && !squash;
        if (oValExp && o_rdy && sb.size() > 0) void'(sb.pop_front());
        if (squash) sb.delete();
        if (acc) begin
            e.op0  = expOperand(d_rs1, d_use_rs1, rf_rdata0);
            e.op1  = expOperand(d_rs2, d_use_rs2, rf_rdata1);
            e.rd   = d_rd;
            e.wen  = d_wen && (d_rd != 5'd0);
            e.ctrl = d_ctrl;
            sb.push_back(e);
        end
        if (d_val && !rdyExp && !squash && stallExp != 32'hFFFF_FFFF) stallExp++;
        oValExp = squash ? 1'b0 : (acc ? 1'b1 : (o_rdy ? 1'b0 : oValExp));
        @(posedge clk);
        @(negedge clk);
        checkOutput("stall_cnt", stall_cnt, stallExp);
    endtask

    task automatic idleInputs();
        d_val = 0; d_rs1 = 0; d_rs2 = 0; d_use_rs1 = 1; d_use_rs2 = 1;
        d_rd = 0; d_wen = 0; d_ctrl = 0; rf_rdata0 = 32'h44; rf_rdata1 = 32'h55;
        x_val = 0; x_wen = 0; x_is_load = 0; x_rd = 0; x_wdata = 0;
        m_val = 0; m_wen = 0; m_rd = 0; m_wdata = 0;
        w_val = 0; w_wen = 0; w_rd = 0; w_wdata = 0;
        squash = 0; o_rdy = 1;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_o_val"},     32'(o_val),  32'd0);
        checkOutput({tag, "_o_op0"},     o_op0,       32'd0);
        checkOutput({tag, "_o_op1"},     o_op1,       32'd0);
        checkOutput({tag, "_o_rd"},      32'(o_rd),   32'd0);
        checkOutput({tag, "_o_wen"},     32'(o_wen),  32'd0);
        checkOutput({tag, "_o_ctrl"},    32'(o_ctrl), 32'd0);
        checkOutput({tag, "_stall_cnt"}, stall_cnt,   32'd0);
    endtask

    initial begin
        idleInputs();
        rst = 1;
        oValExp = 0; stallExp = 0;
        @(negedge clk);
        #1 checkResetState("reset");
        @(negedge clk);
        rst = 0;

        $display("[TB] forward priority");
        d_val = 1; d_rs1 = 5; d_rs2 = 6; d_rd = 9; d_wen = 1; d_ctrl = 8'hA5;
        x_val = 1; x_wen = 1; x_rd = 5; x_wdata = 32'h11;
        m_val = 1; m_wen = 1; m_rd = 5; m_wdata = 32'h22;
        w_val = 1; w_wen = 1; w_rd = 5; w_wdata = 32'h33;
        applyStimulus();
`ifdef OPFETCH_BYPASS_EN
        checkOutput("fwd_x", o_op0, 32'h11);
`endif
        x_val = 0; d_ctrl = 8'h5A;
        applyStimulus();
`ifdef OPFETCH_BYPASS_EN
        checkOutput("fwd_m", o_op0, 32'h22);
`endif
        m_val = 0; d_ctrl = 8'h3C;
        applyStimulus();
`ifdef OPFETCH_BYPASS_EN
        checkOutput("fwd_w", o_op0, 32'h33);
`endif
        w_val = 0; d_ctrl = 8'hC3;
        applyStimulus();

        $display("[TB] load-use");
        idleInputs();
        d_val = 1; d_rs1 = 1; d_rs2 = 7; d_rd = 8; d_wen = 1; d_ctrl = 8'h77;
        x_val = 1; x_wen = 1; x_is_load = 1; x_rd = 7; x_wdata = 32'h1234;
        applyStimulus();
        x_val = 0; x_is_load = 0;
        m_val = 1; m_wen = 1; m_rd = 7; m_wdata = 32'hDEAD_BEEF;
        applyStimulus();
`ifdef OPFETCH_BYPASS_EN
        checkOutput("loaduse_op1", o_op1, 32'hDEAD_BEEF);
        checkOutput("loaduse_stalls", stall_cnt, 32'd1);
`endif
        m_val = 0;
        applyStimulus();

        $display("[TB] x0 and unused source");
        idleInputs();
        d_val = 1; d_rs1 = 0; d_rs2 = 2; d_rd = 0; d_wen = 1; d_ctrl = 8'h01;
        x_val = 1; x_wen = 1; x_is_load = 1; x_rd = 0; x_wdata = 32'hBAD0;
        applyStimulus();
        d_rs1 = 4; d_rs2 = 7; d_use_rs2 = 0; d_rd = 3; d_ctrl = 8'h02; x_rd = 7;
        applyStimulus();
        idleInputs();
        applyStimulus();

        $display("[TB] ALU writer walking X, M, W");
        d_val = 1; d_rs1 = 3; d_rs2 = 0; d_rd = 10; d_wen = 1; d_ctrl = 8'h10;
        x_val = 1; x_wen = 1; x_rd = 3; x_wdata = 32'hAAAA;
        applyStimulus();
        x_val = 0; m_val = 1; m_wen = 1; m_rd = 3; m_wdata = 32'hAAAA;
        applyStimulus();
        m_val = 0; w_val = 1; w_wen = 1; w_rd = 3; w_wdata = 32'hAAAA;
        applyStimulus();
        w_val = 0; rf_rdata0 = 32'hAAAA;
        applyStimulus();
        idleInputs();
        applyStimulus();

        $display("[TB] backpressure and squash");
        d_val = 1; d_rs1 = 1; d_rs2 = 2; d_rd = 11; d_wen = 1; d_ctrl = 8'h20;
        applyStimulus();
        o_rdy = 0; d_rd = 12; d_ctrl = 8'h21; rf_rdata0 = 32'h99;
        repeat (3) applyStimulus();
        squash = 1;
        applyStimulus();
        squash = 0; o_rdy = 1; d_val = 0;
        applyStimulus();
        d_val = 1; d_rd = 13; d_ctrl = 8'h22;
        applyStimulus();
        squash = 1; d_rd = 14; d_ctrl = 8'h23;
        applyStimulus();
        squash = 0; d_val = 0;
        applyStimulus();

        $display("[TB] random traffic");
        for (int i = 0; i < 300; i++) begin
            d_val = ($urandom % 4) != 0;
            d_rs1 = 5'($urandom % 8);  d_rs2 = 5'($urandom % 8);
            d_use_rs1 = 1'($urandom);  d_use_rs2 = 1'($urandom);
            d_rd = 5'($urandom % 8);   d_wen = 1'($urandom);  d_ctrl = 8'($urandom);
            rf_rdata0 = $urandom;      rf_rdata1 = $urandom;
            x_val = 1'($urandom); x_wen = 1'($urandom); x_is_load = ($urandom % 3) == 0;
            x_rd = 5'($urandom % 8); x_wdata = $urandom;
            m_val = 1'($urandom); m_wen = 1'($urandom); m_rd = 5'($urandom % 8); m_wdata = $urandom;
            w_val = 1'($urandom); w_wen = 1'($urandom); w_rd = 5'($urandom % 8); w_wdata = $urandom;
            o_rdy = ($urandom % 4) != 0;
            squash = ($urandom % 16) == 0;
            applyStimulus();
        end

        $display("[TB] asynchronous reset mid-stream");
        idleInputs();
        d_val = 1; d_rs1 = 1; d_rd = 15; d_wen = 1; d_ctrl = 8'h44;
        applyStimulus();
        o_rdy = 0;
        applyStimulus();
        checkOutput("pre_reset_o_val", 32'(o_val), 32'd1);
        rst = 1;
        #1 checkResetState("async_reset");
        sb.delete();
        oValExp = 0; stallExp = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        idleInputs();
        #1 checkOutput("post_reset_d_rdy", 32'(d_rdy), 32'd1);
        @(negedge clk);
        d_val = 1; d_rs1 = 2; d_rd = 16; d_wen = 1; d_ctrl = 8'h55;
        applyStimulus();
        d_val = 0;
        applyStimulus();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Register-read / operand-fetch stage of the TinyRV1 pipeline, between decode and execute. Drives the register file's two read ports, selects each source operand from the register file or a bypass path (X, M, W), and stalls on load-use hazards. Results go into a single-entry output pipeline register with a val/rdy handshake on both sides. A saturating stall counter supports performance debug.

## Interface
- CTRL_W, 8, width of the opaque decoded-control bundle passed through to execute
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- d_val  in  1  decode presents an instruction
- d_rdy  out  1  stage accepts the instruction this cycle
- d_rs1, d_rs2  in  5  source register addresses
- d_use_rs1, d_use_rs2  in  1  source actually read by the instruction
- d_rd  in  5  destination register
- d_wen  in  1  instruction writes d_rd
- d_ctrl  in  CTRL_W  decoded control, passed through untouched
- rf_raddr0, rf_raddr1  out  5  register file read addresses (combinational copies of d_rs1/d_rs2)
- rf_rdata0, rf_rdata1  in  32  register file read data (combinational; x0 reads 0)
- x_val, x_wen, x_is_load  in  1  execute-stage instruction status
- x_rd  in  5  execute destination
- x_wdata  in  32  execute ALU result
- m_val, m_wen  in  1; m_rd  in  5; m_wdata  in  32  memory-stage writer
- w_val, w_wen  in  1; w_rd  in  5; w_wdata  in  32  writeback-stage writer (same cycle as the regfile write)
- squash  in  1  redirect: kill the in-flight output and any accepted input
- o_val  out  1  output register holds a valid instruction
- o_rdy  in  1  execute accepts
- o_op0, o_op1  out  32  resolved operands
- o_rd  out  5; o_wen  out  1; o_ctrl  out  CTRL_W  registered pass-through
- stall_cnt  out  32  count of stall cycles, saturating

## Operation
- Match rule for stage S in {x, m, w} and source s: S_val and S_wen and S_rd == s and s != 0 and the source's d_use_* bit is set.
- Operand select, highest priority first:
  - s == 0 gives 0.
  - Otherwise X match gives x_wdata, then M match gives m_wdata, then W match gives w_wdata.
  - Otherwise rf_rdata.
- hazard = d_val and (an X match on a used source with x_is_load set).
- accept = d_val and d_rdy and not squash.
- d_rdy = not hazard and (not o_val or o_rdy).
- On accept: the output register loads operands, d_rd, d_wen, d_ctrl, and o_val becomes 1.
- Without accept: o_val clears when o_rdy is high, otherwise it holds. Held contents stay stable while o_val=1 and o_rdy=0.
- squash (top priority): o_val clears next cycle and nothing is loaded, regardless of d_val and o_rdy.
- stall_cnt increments each cycle d_val=1 and d_rdy=0 and squash=0. It saturates at 0xFFFF_FFFF.
- o_wen is forced to 0 when o_rd == 0.

## Timing
- Latency is 1 cycle. An instruction accepted at edge N is on o_* after edge N.
- Full throughput of 1 instruction/cycle with no hazard and o_rdy held high.
- Reset (asynchronous, any time, including mid-stall) sets:
  - o_val=0, o_op0=o_op1=0, o_rd=0, o_wen=0, o_ctrl=0
  - stall_cnt=0
- After reset deasserts, d_rdy=1 while there is no hazard.
- d_rdy, rf_raddr* and the bypass muxes are combinational. There is no combinational path from d_val to d_rdy except through hazard.
- d_rdy must not depend on squash.
- A load-use hazard costs exactly 1 stall cycle, once the load advances to M and is forwarded from m_wdata.
- Backpressure and hazard in the same cycle stall once; stall_cnt counts it once.

## Configuration
- OPFETCH_BYPASS_EN defined: bypass operates as described under Operation.
- OPFETCH_BYPASS_EN undefined:
  - No forwarding; operands always come from rf_rdata (x0 still reads 0).
  - hazard = d_val and (any X, M or W match on a used source, regardless of x_is_load).
  - W is included in the hazard because the regfile write lands on the clock edge, after the read.

## Structure
- Shared package tinyrv1_pkg holds:
  - REG_ZERO = 5'd0
  - XLEN = 32
  - typedef byp_sel_t enum {BYP_ZERO, BYP_X, BYP_M, BYP_W, BYP_RF}
- Sub-module operand_bypass, instantiated twice (one per source):
  - inputs: source address, use bit, the X/M/W match fields and data, rf data
  - outputs: the 32-bit operand and a load-hazard flag
  - contents selected by OPFETCH_BYPASS_EN
- Top level holds the handshake, the output register and stall_cnt.

## Test plan
- Reset mid-stream: with o_val=1, assert rst asynchronously → o_val=0, stall_cnt=0 immediately. d_rdy=1 after deassert.
- Forward priority (bypass on): d_rs1=5, with X writing 5=0x11, M writing 5=0x22, W writing 5=0x33, and rf=0x44 → o_op0=0x11. Drop X → 0x22. Drop M → 0x33.
- Load-use (bypass on): X is a load to rd=7; d_rs2=7 with d_use_rs2=1 → d_rdy=0 for 1 cycle and stall_cnt=1. Next cycle, with M forwarding 0xDEAD_BEEF → o_op1=0xDEAD_BEEF.
- x0 and unused source: d_rs1=0 while X writes rd=0 → o_op0=0. d_use_rs2=0 with an X-load match → no stall.
- Backpressure and squash:
  - Hold o_rdy=0 for 3 cycles → o_* stable and d_rdy=0.
  - Assert squash with d_val=1 → o_val=0 next cycle and the instruction is not loaded.
- Bypass off: X ALU writer to rd=3, d_rs1=3 → stall until X, M and W no longer match (3 cycles). Then o_op0=rf_rdata0.
